jk_stim_ctrl: RTL and testbench
===============================

Name: jk_stim_ctrl

Overview:
- Initiator/checker for a single JK flip-flop under test. It accepts flop operations on a valid/ready command port, buffers them, and drives the flop's j, k and reset.
- It samples the flop's q/qb outputs, compares them against an internal JK model, and reports mismatches.
- It sits beside the JK flop: it drives that flop's inputs and consumes its outputs.

Parameters:
- DEPTH, 4, command FIFO depth; power of two, at least 2.
- INIT_CYCLES, 4, number of cycles ff_rst_n is held low after reset release; at least 1.
- CW, 8, width of the err_cnt and chk_cnt counters.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- cmd_ready  out  1  command accepted on a clk edge when cmd_valid && cmd_ready.
- run_en  in  1  1 = issue commands from the FIFO; 0 = stall issue.
- cnt_clr  in  1  synchronous clear of err_cnt, chk_cnt and err_sticky.
- j  out  1  registered drive to the flop under test.
- k  out  1  registered drive to the flop under test.
- ff_rst_n  out  1  registered reset to the flop under test, active-low.
- q  in  1  flop output.
- qb  in  1  flop complementary output.
- busy  out  1  FIFO non-empty or a check still pending.
- err_pulse  out  1  one-cycle pulse per detected mismatch.
- err_sticky  out  1  set on any mismatch; cleared by rst or cnt_clr.
- err_cnt  out  CW  mismatch count; saturates at all-ones.
- chk_cnt  out  CW  completed-check count; saturates at all-ones.

Behaviour:
- rst low, asynchronous: FIFO empty, state INIT, init counter 0.
  - Outputs: j=0, k=0, ff_rst_n=0, cmd_ready=0, busy=0, err_pulse=0, err_sticky=0, err_cnt=0, chk_cnt=0.
  - Model q_exp=0; check pipeline valid bits cleared.
  - Assertion mid-operation discards all queued and in-flight commands.
- FSM INIT:
  - ff_rst_n=0, cmd_ready=0.
  - After INIT_CYCLES edges following rst release, ff_rst_n goes to 1 and state goes to RUN.
  - Example: INIT_CYCLES=4 gives exactly 4 cycles with ff_rst_n=0.
- FSM RUN: cmd_ready = !full. Full is evaluated before any same-cycle pop, so no push is accepted while full. RUN has no exit other than rst.
- FIFO:
  - Push on an accepted command.
  - Pop when RUN && run_en && !empty.
  - Simultaneous push and pop is allowed when not full.
  - No bypass: a command accepted at edge t issues at edge t+1 at the earliest.
  - Pointers wrap modulo DEPTH.
- Issue edge E:
  - Pop case: register j/k from the popped op (HOLD 0/0, RESET 0/1, SET 1/0, TOGGLE 1/1) and update q_exp per the JK equation (RESET→0, SET→1, TOGGLE→~q_exp, HOLD unchanged).
  - Push an entry {valid=1, exp=new q_exp} into a 2-stage check pipeline.
  - No-pop case: j=k=0, push {valid=0}.
- Check timing:
  - The flop samples j/k at E+1.
  - At edge E+2 the controller samples q/qb and compares the stage-2 entry.
- Check result, for valid entries only:
  - Mismatch if q!=exp or qb!=~q.
  - On mismatch: err_pulse=1 for that one cycle, err_sticky=1, err_cnt+1 (saturating).
  - chk_cnt+1 (saturating) for every valid check, matched or not.
- cnt_clr:
  - Clears err_cnt, chk_cnt and err_sticky at the edge.
  - A mismatch on the same edge wins: the counter ends at 1 and err_sticky ends at 1.
  - chk_cnt likewise ends at 1 if a check completes on the same edge.
- busy = !empty || either pipeline stage valid.

Decomposition:
- Package jk_stim_pkg:
  - op enum typedef: HOLD, RESET, SET, TOGGLE.
  - state enum typedef: INIT, RUN.
  - check-entry struct {valid, exp}.
  - Function jk_next(op, q) returning the next flop state.
- Sub-module jk_cmd_fifo:
  - Parameterised DEPTH, width 2.
  - Ports: push, pop, din, dout, full, empty.
  - Asynchronous active-low reset on rst.
- Top module: FSM, init counter, drive registers, model, check pipeline, counters.

Test Plan:
1. Release rst, INIT_CYCLES=4 → ff_rst_n=0 and cmd_ready=0 for 4 cycles, then ff_rst_n=1 and cmd_ready=1; j=k=0 throughout.
2. Correct flop, run_en=1, commands SET, TOGGLE, TOGGLE, RESET, HOLD → q sampled 1,0,1,0,0; err_cnt=0, chk_cnt=5, busy falls 2 cycles after the last issue.
3. Flop model with q stuck at 0, command SET at issue edge E → err_pulse high at E+2 only, err_sticky=1, err_cnt=1; a following RESET does not raise an error.
4. run_en=0, cmd_valid held for 6 cycles → 4 accepted, cmd_ready=0 while full. Then run_en=1 → one issue per cycle, cmd_ready=1 after the first pop, order preserved.
5. Flop model forces qb=q, command HOLD → mismatch, err_cnt=1. Then cnt_clr coincident with a second mismatch → err_cnt=1, err_sticky=1.
6. Assert rst with 3 commands queued and 2 checks in flight → outputs return to reset values immediately, no err_pulse, chk_cnt=0; the INIT sequence repeats on release.

Source files
------------

// File: rtl/jk_stim_pkg.sv
// Shared types for the JK flop stimulus/checker: operation codes, controller
// states, check-pipeline entry and the reference next-state function.
package jk_stim_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic exp;
  } chk_entry_t;

  function automatic logic jk_next(input op_t op, input logic q);
    logic nq;
    case (op)
      OP_RESET:  nq = 1'b0;
      OP_SET:    nq = 1'b1;
      OP_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small command FIFO holding 2-bit flop operations; pointers wrap naturally
// because DEPTH is a power of two.
module jk_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jk_stim_ctrl.sv
// Drives a JK flop under test from a queued command stream and checks its
// q/qb outputs two edges after each issue against an internal JK model.
module jk_stim_ctrl
  import jk_stim_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INIT_CYCLES = 4,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  output logic          cmd_ready,
  input  logic          run_en,
  input  logic          cnt_clr,
  output logic          j,
  output logic          k,
  output logic          ff_rst_n,
  input  logic          q,
  input  logic          qb,
  output logic          busy,
  output logic          err_pulse,
  output logic          err_sticky,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] chk_cnt
);

  localparam int IW = $clog2(INIT_CYCLES + 1);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] init_cnt;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_dout;
  logic          q_exp;
  logic          q_exp_next;
  chk_entry_t    stage1;
  chk_entry_t    stage2;
  logic          chk_done;
  logic          mismatch;
  logic [CW-1:0] err_base;
  logic [CW-1:0] chk_base;

  jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cmd_op),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == IW'(INIT_CYCLES - 1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        cmd_ready = !fifo_full;
        pop       = run_en && !fifo_empty;
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign push = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt <= '0;
      ff_rst_n <= 1'b0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      ff_rst_n <= (state_next == ST_RUN);
    end
  end

  assign q_exp_next = jk_next(op_t'(fifo_dout), q_exp);

  // Issue stage: an idle edge still shifts an invalid entry so checks stay two edges behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j      <= 1'b0;
      k      <= 1'b0;
      q_exp  <= 1'b0;
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage2 <= stage1;
      if (pop) begin
        j      <= fifo_dout[1];
        k      <= fifo_dout[0];
        q_exp  <= q_exp_next;
        stage1 <= '{valid: 1'b1, exp: q_exp_next};
      end else begin
        j      <= 1'b0;
        k      <= 1'b0;
        stage1 <= '{valid: 1'b0, exp: q_exp};
      end
    end
  end

  assign chk_done = stage2.valid;
  assign mismatch = stage2.valid && ((q != stage2.exp) || (qb == q));

  // Clear applies first so a same-edge event still counts.
  always_comb begin
    err_base = cnt_clr ? '0 : err_cnt;
    chk_base = cnt_clr ? '0 : chk_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      chk_cnt    <= '0;
    end else begin
      err_pulse  <= mismatch;
      err_sticky <= (err_sticky && !cnt_clr) || mismatch;
      if (mismatch && (err_base != '1)) err_cnt <= err_base + 1'b1;
      else                               err_cnt <= err_base;
      if (chk_done && (chk_base != '1)) chk_cnt <= chk_base + 1'b1;
      else                               chk_cnt <= chk_base;
    end
  end

  assign busy = !fifo_empty || stage1.valid || stage2.valid;

endmodule

// File: tb/tb_jk_stim_ctrl.sv
// Self-checking bench for jk_stim_ctrl: a faultable JK flop model plus a
// transaction-level reference built from queues of commands and due checks.
module tb_jk_stim_ctrl;

  localparam int DEPTH       = 4;
  localparam int INIT_CYCLES = 4;
  localparam int CW          = 8;
  localparam int MAXC        = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic          run_en = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          cmd_ready, j, k, ff_rst_n, q, qb, busy, err_pulse, err_sticky;
  logic [CW-1:0] err_cnt, chk_cnt;

  int   fault_mode = 0;
  logic flop_q = 1'b0;
  int   checks = 0;
  int   errors = 0;

  jk_stim_ctrl #(.DEPTH(DEPTH), .INIT_CYCLES(INIT_CYCLES), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .run_en     (run_en),
    .cnt_clr    (cnt_clr),
    .j          (j),
    .k          (k),
    .ff_rst_n   (ff_rst_n),
    .q          (q),
    .qb         (qb),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .chk_cnt    (chk_cnt)
  );

  always #5 clk = ~clk;

  // Flop under test; fault 1 sticks q at 0, fault 2 forces qb equal to q.
  always @(posedge clk or negedge ff_rst_n) begin
    if (!ff_rst_n) flop_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end
  assign q  = (fault_mode == 1) ? 1'b0 : flop_q;
  assign qb = (fault_mode == 2) ? q : ~q;

  typedef struct {
    int   due;
    logic exp;
  } pend_t;

  logic [1:0] fifo_m[$];
  pend_t      pend_m[$];
  int         cyc, edge_n, err_m, chk_m;
  logic       q_m, ej, ek, epulse, esticky;

  task automatic model_reset();
    fifo_m.delete();
    pend_m.delete();
    cyc = 0; err_m = 0; chk_m = 0;
    q_m = 0; ej = 0; ek = 0; epulse = 0; esticky = 0;
  endtask

  task automatic model_edge();
    bit         run_pre  = (cyc >= INIT_CYCLES);
    bit         ready_pre = run_pre && (fifo_m.size() < DEPTH);
    bit         pop_m    = run_pre && run_en && (fifo_m.size() > 0);
    bit         mis = 0;
    bit         done = 0;
    logic [1:0] op;
    pend_t      p;
    if (pend_m.size() > 0 && pend_m[0].due == edge_n) begin
      done = 1;
      if (fault_mode == 0)      mis = 0;
      else if (fault_mode == 1) mis = pend_m[0].exp;
      else                      mis = 1;
      void'(pend_m.pop_front());
    end
    if (cnt_clr) begin err_m = 0; chk_m = 0; esticky = 0; end
    if (mis) begin esticky = 1; if (err_m < MAXC) err_m++; end
    if (done && chk_m < MAXC) chk_m++;
    epulse = mis;
    ej = 0; ek = 0;
    if (pop_m) begin
      op = fifo_m.pop_front();
      if (op == 2'd1)      q_m = 0;
      else if (op == 2'd2) q_m = 1;
      else if (op == 2'd3) q_m = !q_m;
      ej = (op == 2'd2) || (op == 2'd3);
      ek = (op == 2'd1) || (op == 2'd3);
      p.due = edge_n + 2;
      p.exp = q_m;
      pend_m.push_back(p);
    end
    if (cmd_valid && ready_pre) fifo_m.push_back(cmd_op);
    if (cyc < INIT_CYCLES) cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("cmd_ready",  32'(cmd_ready),  32'((cyc >= INIT_CYCLES) && (fifo_m.size() < DEPTH)));
    chk("ff_rst_n",   32'(ff_rst_n),   32'(cyc >= INIT_CYCLES));
    chk("j",          32'(j),          32'(ej));
    chk("k",          32'(k),          32'(ek));
    chk("busy",       32'(busy),       32'((fifo_m.size() > 0) || (pend_m.size() > 0)));
    chk("err_pulse",  32'(err_pulse),  32'(epulse));
    chk("err_sticky", 32'(err_sticky), 32'(esticky));
    chk("err_cnt",    32'(err_cnt),    32'(err_m));
    chk("chk_cnt",    32'(chk_cnt),    32'(chk_m));
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] op, input bit run, input bit clr);
    cmd_valid = v;
    cmd_op    = op;
    run_en    = run;
    cnt_clr   = clr;
    @(posedge clk);
    edge_n++;
    if (rst) model_edge();
    #1;
    checkOutput();
  endtask

  task automatic drain(input bit clr_on_check);
    int n = 0;
    while (((fifo_m.size() > 0) || (pend_m.size() > 0)) && n < 64) begin
      applyStimulus(0, 2'b00, 1,
                    clr_on_check && (pend_m.size() > 0) && (pend_m[0].due == edge_n + 1));
      n++;
    end
    chk("drain_bound", 32'(n < 64), 32'd1);
  endtask

  task automatic do_init();
    rst = 1'b1;
    repeat (INIT_CYCLES + 1) applyStimulus(0, 2'b00, 1, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] seq [5];
    edge_n = 0;
    model_reset();
    $display("[TB] reset and init sequence");
    repeat (2) applyStimulus(0, 2'b00, 0, 0);
    do_init();

    $display("[TB] correct flop: SET TOGGLE TOGGLE RESET HOLD");
    fault_mode = 0;
    seq = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd0};
    for (int i = 0; i < 5; i++) applyStimulus(1, seq[i], 1, 0);
    drain(0);

    $display("[TB] q stuck at 0: SET then RESET");
    fault_mode = 1;
    applyStimulus(1, 2'd2, 1, 0);
    applyStimulus(1, 2'd1, 1, 0);
    drain(0);

    $display("[TB] fill while stalled, then release");
    fault_mode = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1, 2'($urandom_range(0, 3)), 0, 0);
    drain(0);

    $display("[TB] qb equals q, then clear coincident with mismatch");
    fault_mode = 2;
    applyStimulus(1, 2'd0, 1, 0);
    drain(0);
    applyStimulus(1, 2'd0, 1, 0);
    drain(1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) fault_mode = int'($urandom_range(0, 2));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    drain(0);

    $display("[TB] counter saturation");
    fault_mode = 2;
    applyStimulus(0, 2'd0, 1, 1);
    for (int i = 0; i < 270; i++) applyStimulus(1, 2'd0, 1, 0);
    drain(0);

    $display("[TB] reset with work queued and checks in flight");
    fault_mode = 0;
    applyStimulus(1, 2'd2, 1, 0);
    applyStimulus(1, 2'd3, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'($urandom_range(0, 3)), 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    checkOutput();
    repeat (2) applyStimulus(0, 2'b00, 1, 0);
    do_init();
    applyStimulus(1, 2'd2, 1, 0);
    applyStimulus(1, 2'd3, 1, 0);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
